conv_enc_ctrl: RTL
==================

// Module: conv_enc_ctrl
// PURPOSE
//  Frame sequencer for the 802.11a convolutional encoder (K=7, g0=133, g1=171). Pulls data bits from the
//  scrambler via valid/ready, drives encoder bit/shift/A-B select per puncturing pattern, appends 6 zero tail
//  bits, optionally pads to a whole OFDM symbol. Sits between scrambler and interleaver; owns encoder sequencing.
// PARAMETERS
//  LEN_W    16  width of frame data-bit count
//  DBPS_W   9   width of data-bits-per-OFDM-symbol (max 216)
//  TAIL_LEN 6   zero tail bits appended after data
// PORTS
//  Clk        in   1       clock, all state on rising edge
//  reset      in   1       asynchronous, active-high reset
//  start      in   1       frame start pulse; sampled in IDLE only
//  rate_sel   in   2       0:1/2  1:2/3  2:3/4  3:illegal
//  n_bits     in   LEN_W   data bits in frame (0 legal)
//  n_dbps     in   DBPS_W  data bits per OFDM symbol (padding only; must be >0)
//  src_bit    in   1       data bit from scrambler
//  src_valid  in   1       src_bit valid
//  src_ready  out  1       bit accepted when src_valid&src_ready
//  enc_clr    out  1       clear encoder shift register (1-cycle pulse)
//  enc_bit    out  1       current input bit to encoder
//  enc_sel    out  1       0: emit A (g0), 1: emit B (g1)
//  enc_shift  out  1       shift enc_bit into encoder at this edge
//  coded_vld  out  1       encoder output valid this cycle
//  busy       out  1       high from start accept to DONE exit
//  done       out  1       1-cycle pulse at frame end
//  err        out  1       1-cycle pulse: start with rate_sel==3 rejected
// BEHAVIOUR
//  - Reset (any time, incl. mid-frame): state IDLE, all counters 0, every output 0. Frame abandoned.
//  - FSM: IDLE -start(rate ok)-> CLR -> DATA (n_bits>0) or TAIL -> PAD (macro, sym_cnt!=0) or DONE -> IDLE.
//  - start with rate_sel==3: err=1 next cycle, stay IDLE. start while busy: ignored.
//  - rate_sel,n_bits,n_dbps latched on accepted start; input changes afterwards have no effect.
//  - CLR: enc_clr=1 one cycle (start at t -> enc_clr at t+1 -> first DATA cycle t+2).
//  - Phase counter ph 0..P-1, P=rate+2. Table (sel,shift) per ph:
//      1/2: (A,0)(B,1)        2/3: (A,0)(B,1)(A,1)        3/4: (A,0)(B,1)(A,1)(B,1)
//    i.e. A0 B0 A1 [B2]; one shift per input bit; P coded bits per rate+1 input bits.
//  - 1-entry holding reg feeds enc_bit. src_ready = DATA & data_left>0 & (hold empty | enc_shift).
//  - coded_vld = hold full (DATA) or TAIL/PAD active; ph advances only when coded_vld. Empty hold in DATA
//    = stall: coded_vld=0, enc_shift=0, ph frozen, no encoder state change.
//  - TAIL/PAD: enc_bit=0, no source access, never stalls; tail_cnt counts shifts to TAIL_LEN.
//  - Phase continues across DATA->TAIL->PAD boundaries (puncture pattern unbroken); frame ends on the
//    shift of the last bit, so final period may be partial; ph reset to 0 in CLR.
//  - sym_cnt counts shifted bits (data+tail+pad), wraps n_dbps-1 -> 0.
//  - DONE: done=1, busy=0 one cycle, return IDLE. Total coded bits = ceil-free sum of emitted phases.
// CONFIGURATION
//  CONV_ENC_CTRL_PAD_EN defined: after TAIL, if sym_cnt!=0 enter PAD, shift zeros until sym_cnt wraps to 0.
//  Undefined: TAIL -> DONE directly; sym_cnt and n_dbps logic removed (n_dbps unused).
// STRUCTURE
//  conv_enc_pkg: rate_e (R12,R23,R34), state_e, TAIL_LEN, puncture table function (rate,ph)->(sel,shift),
//  period function rate->P. Sub-module conv_punct_sched: ph counter + table lookup, inputs rate/adv/clr.
// TESTING
//  1/2, n_bits=4, src_valid=1: enc_sel 0101.. , 10 shifts (4 data+6 tail), 20 coded_vld, done once.
//  3/4, n_bits=3: sel A,B,A,B then tail; shift on ph1,2,3 only; 9 shifts total, 12 coded bits.
//  2/3, src_valid low 5 cycles mid-frame: coded_vld/ph/enc_shift frozen, no bit lost or duplicated.
//  PAD_EN, n_dbps=24, 1/2, n_bits=10: 16 bits+8 pad shifts = 24; sym_cnt 0 at done; without macro 16.
//  n_bits=0: CLR then 6 tail shifts only; rate_sel=3: err pulse, busy stays 0.
//  reset asserted mid-DATA: all outputs 0 asynchronously; next start runs clean frame from CLR.

Source files
------------

// File: rtl/conv_enc_pkg.sv
// Shared types and puncturing tables for the 802.11a conv encoder sequencer.
// Rates 1/2, 2/3, 3/4; phase table (sel,shift) indexed by rate and phase.
package conv_enc_pkg;

  localparam int TAIL_LEN = 6;

  typedef enum logic [1:0] {
    R12 = 2'd0,
    R23 = 2'd1,
    R34 = 2'd2
  } rate_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_DATA,
    S_TAIL,
    S_PAD,
    S_DONE
  } state_e;

  typedef struct packed {
    logic sel;
    logic shift;
  } punct_t;

  // Coded bits per puncturing period: rate index + 2.
  function automatic logic [2:0] period(rate_e r);
    logic [2:0] p;
    unique case (r)
      R12:     p = 3'd2;
      R23:     p = 3'd3;
      R34:     p = 3'd4;
      default: p = 3'd2;
    endcase
    return p;
  endfunction

  // Emitted output (A/B) and whether the bit shifts in this phase.
  // Pattern is A0 B0 A1 B2; phases past the period never occur.
  function automatic punct_t punct(rate_e r, logic [1:0] ph);
    punct_t p;
    unique case (ph)
      2'd0:    p = '{sel: 1'b0, shift: 1'b0};
      2'd1:    p = '{sel: 1'b1, shift: 1'b1};
      2'd2:    p = '{sel: 1'b0, shift: (r != R12)};
      default: p = '{sel: 1'b1, shift: (r == R34)};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/conv_punct_sched.sv
// Puncture phase counter for the conv encoder sequencer.
// Advances only on coded-bit cycles so stalls freeze the pattern.
module conv_punct_sched
  import conv_enc_pkg::*;
(
  input  logic  Clk,
  input  logic  reset,
  input  rate_e rate,
  input  logic  adv,
  input  logic  clr,
  output logic  sel,
  output logic  shift
);

  logic [1:0] ph;
  logic       ph_last;
  punct_t     cur;

  assign ph_last = ({1'b0, ph} == (period(rate) - 3'd1));
  assign cur     = punct(rate, ph);
  assign sel     = cur.sel;
  assign shift   = cur.shift;

  // Phase register: cleared per frame, wraps at the rate's period.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      ph <= 2'd0;
    end else if (clr) begin
      ph <= 2'd0;
    end else if (adv) begin
      ph <= ph_last ? 2'd0 : ph + 2'd1;
    end
  end

endmodule

// File: rtl/conv_enc_ctrl.sv
// Frame sequencer: scrambler -> K=7 conv encoder, puncture, 6-bit tail.
// CONV_ENC_CTRL_PAD_EN: zero-pad the frame to a whole OFDM symbol.
module conv_enc_ctrl #(
  parameter int LEN_W    = 16,
  parameter int DBPS_W   = 9,
  parameter int TAIL_LEN = conv_enc_pkg::TAIL_LEN
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        rate_sel,
  input  logic [LEN_W-1:0]  n_bits,
  input  logic [DBPS_W-1:0] n_dbps,
  input  logic              src_bit,
  input  logic              src_valid,
  output logic              src_ready,
  output logic              enc_clr,
  output logic              enc_bit,
  output logic              enc_sel,
  output logic              enc_shift,
  output logic              coded_vld,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import conv_enc_pkg::*;

  localparam int TW = $clog2(TAIL_LEN + 1);

  state_e           state;
  state_e           state_nxt;
  rate_e            rate_q;
  logic [LEN_W-1:0] left_q;
  logic             hold_vld;
  logic             hold_bit;
  logic [TW-1:0]    tail_cnt;
  logic             err_q;

  logic in_data;
  logic in_tail;
  logic in_pad;
  logic acc_start;
  logic bad_start;
  logic src_fire;
  logic pun_sel;
  logic pun_shift;
  logic last_data;
  logic last_tail;
  logic sym_wrap;

  assign in_data   = (state == S_DATA);
  assign in_tail   = (state == S_TAIL);
  assign in_pad    = (state == S_PAD);
  assign bad_start = (state == S_IDLE) && start
                   && (rate_sel == 2'd3);
  assign acc_start = (state == S_IDLE) && start
                   && (rate_sel != 2'd3);

  assign coded_vld = (in_data && hold_vld)
                   || in_tail || in_pad;
  assign enc_shift = coded_vld && pun_shift;
  assign enc_sel   = coded_vld && pun_sel;
  assign enc_bit   = in_data && hold_vld && hold_bit;
  assign enc_clr   = (state == S_CLR);
  assign busy      = enc_clr || in_data
                   || in_tail || in_pad;
  assign done      = (state == S_DONE);
  assign err       = err_q;

  // Refill the holding reg when empty or when it shifts out this cycle.
  assign src_ready = in_data && (left_q != '0)
                   && (!hold_vld || enc_shift);
  assign src_fire  = src_valid && src_ready;

  assign last_data = in_data && enc_shift
                   && (left_q == '0);
  assign last_tail = in_tail && enc_shift
                   && (tail_cnt == TW'(TAIL_LEN - 1));

  conv_punct_sched u_sched (
    .Clk   (Clk),
    .reset (reset),
    .rate  (rate_q),
    .adv   (coded_vld),
    .clr   (enc_clr),
    .sel   (pun_sel),
    .shift (pun_shift)
  );

`ifdef CONV_ENC_CTRL_PAD_EN
  logic [DBPS_W-1:0] dbps_q;
  logic [DBPS_W-1:0] sym_cnt;

  assign sym_wrap = enc_shift
                  && (sym_cnt == dbps_q - 1'b1);

  // Symbol position: counts every shifted bit, wraps at n_dbps.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      dbps_q  <= '0;
      sym_cnt <= '0;
    end else begin
      if (acc_start) begin
        dbps_q <= n_dbps;
      end
      if (enc_clr) begin
        sym_cnt <= '0;
      end else if (enc_shift) begin
        sym_cnt <= sym_wrap ? '0 : sym_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_dbps;

  assign unused_dbps = ^n_dbps;
  assign sym_wrap    = 1'b1;
`endif

  // State register.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: data, then tail, then optional pad.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (acc_start) state_nxt = S_CLR;
      end
      S_CLR: begin
        state_nxt = (left_q != '0) ? S_DATA : S_TAIL;
      end
      S_DATA: begin
        if (last_data) state_nxt = S_TAIL;
      end
      S_TAIL: begin
        if (last_tail) begin
`ifdef CONV_ENC_CTRL_PAD_EN
          state_nxt = sym_wrap ? S_DONE : S_PAD;
`else
          state_nxt = S_DONE;
`endif
        end
      end
      S_PAD: begin
        if (sym_wrap) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame parameters, holding register and tail counter.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      rate_q   <= R12;
      left_q   <= '0;
      hold_vld <= 1'b0;
      hold_bit <= 1'b0;
      tail_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= bad_start;
      if (acc_start) begin
        rate_q <= rate_e'(rate_sel);
        left_q <= n_bits;
      end else if (src_fire) begin
        left_q <= left_q - 1'b1;
      end
      if (enc_clr) begin
        hold_vld <= 1'b0;
      end else if (src_fire) begin
        hold_vld <= 1'b1;
        hold_bit <= src_bit;
      end else if (in_data && enc_shift) begin
        hold_vld <= 1'b0;
      end
      if (enc_clr) begin
        tail_cnt <= '0;
      end else if (in_tail && enc_shift) begin
        tail_cnt <= tail_cnt + 1'b1;
      end
    end
  end

endmodule
